// File: rtl/zero_mem_bridge_pkg.sv
// Shared encodings for zero_mem_bridge: access sizes, RAM base, pending-response
// record and the size/offset helpers used by the store/load lane logic.
package zero_mem_bridge_pkg;

  localparam logic [63:0] RAM_BASE_ADDR = 64'h8000_0000;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;
  localparam logic [1:0] MEM_SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    PEND_SRC_IF    = 2'd0,
    PEND_SRC_LS    = 2'd1,
    PEND_SRC_STORE = 2'd2,
    PEND_SRC_ERR   = 2'd3
  } pend_src_e;

  typedef struct packed {
    logic      vld;
    pend_src_e src;
    logic [2:0] off;
    logic [1:0] size;
  } pend_t;

  // LSB-aligned bit mask covering the bytes of one access of the given size
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: return 64'h0000_0000_0000_00FF;
      MEM_SIZE_H: return 64'h0000_0000_0000_FFFF;
      MEM_SIZE_W: return 64'h0000_0000_FFFF_FFFF;
      default:    return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      MEM_SIZE_H: return off[0];
      MEM_SIZE_W: return off[1:0] != 2'b00;
      MEM_SIZE_D: return off != 3'b000;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/zero_mem_bridge_store_align.sv
// zero_store_align: size/offset lane logic. Store side shifts data and builds the
// bit mask; load side extracts the addressed lanes of a RAM word to the LSB.
module zero_store_align
  import zero_mem_bridge_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [2:0]  i_off,
  input  logic [63:0] i_wdata,
  output logic [63:0] o_wdata,
  output logic [63:0] o_wmask,
  output logic        o_misaligned,
  input  logic [1:0]  i_ld_size,
  input  logic [2:0]  i_ld_off,
  input  logic [63:0] i_ld_rdata,
  output logic [63:0] o_ld_data
);

  logic [5:0] w_st_shift;
  logic [5:0] w_ld_shift;

  assign w_st_shift   = {i_off, 3'b000};
  assign w_ld_shift   = {i_ld_off, 3'b000};

  assign o_wdata      = i_wdata << w_st_shift;
  assign o_wmask      = size_mask(i_size) << w_st_shift;
  assign o_misaligned = misaligned(i_size, i_off);

  assign o_ld_data    = (i_ld_rdata >> w_ld_shift) & size_mask(i_ld_size);

endmodule

// File: rtl/zero_mem_bridge.sv
// zero_mem_bridge: maps zerocore fetch and load/store ports onto a RAMHelper read/write pair.
// Optional MEM_BRIDGE_PERF_EN adds saturating fetch-stall and LS-request counters.
module zero_mem_bridge
  import zero_mem_bridge_pkg::*;
#(
  parameter logic [63:0] RAM_BASE = RAM_BASE_ADDR,
  parameter int          DATA_W   = 64
) (
  input  logic        clk,
  input  logic        rst,
`ifdef MEM_BRIDGE_PERF_EN
  output logic [31:0] perf_if_stall,
  output logic [31:0] perf_ls_cnt,
`endif
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_inst,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic        ls_req_we,
  input  logic [1:0]  ls_req_size,
  input  logic [63:0] ls_req_addr,
  input  logic [63:0] ls_req_wdata,
  output logic        ls_rsp_valid,
  output logic [63:0] ls_rsp_rdata,
  output logic        ls_rsp_err,
  output logic        ram_ren,
  output logic [63:0] ram_ridx,
  input  logic [63:0] ram_rdata,
  output logic        ram_wen,
  output logic [63:0] ram_widx,
  output logic [63:0] ram_wdata,
  output logic [63:0] ram_wmask
);

  if (DATA_W != 64) begin : g_bad_data_w
    $error("zero_mem_bridge: DATA_W must be 64");
  end

  logic        w_ls_mis;
  logic        w_ld_hit;
  logic        w_st_hit;
  logic        w_if_hit;
  logic [63:0] w_ls_idx;
  logic [63:0] w_if_idx;
  logic [63:0] w_st_wdata;
  logic [63:0] w_st_wmask;
  logic [63:0] w_ld_data;
  pend_t       r_ls_pend;
  logic        r_if_vld;
  logic        r_if_hi;

  // Handshake: a request is taken in any cycle where valid && ready; its response
  // appears exactly one cycle later with no backpressure. LS is always ready.
  assign w_ld_hit = ls_req_valid && !ls_req_we && !w_ls_mis;
  assign w_st_hit = ls_req_valid &&  ls_req_we && !w_ls_mis;
  assign w_if_hit = if_req_valid && !w_ld_hit;

  assign w_ls_idx = (ls_req_addr - RAM_BASE) >> 3;
  assign w_if_idx = (if_req_addr - RAM_BASE) >> 3;

  // Decisions above stay free of rst so flops never sample the reset net; outputs are gated here
  assign ls_req_ready = 1'b1;
  assign if_req_ready = rst && !w_ld_hit;
  assign ram_ren      = rst && (w_ld_hit || w_if_hit);
  assign ram_ridx     = !rst ? '0 : (w_ld_hit ? w_ls_idx : (w_if_hit ? w_if_idx : '0));
  assign ram_wen      = rst && w_st_hit;
  assign ram_widx     = ram_wen ? w_ls_idx   : '0;
  assign ram_wdata    = ram_wen ? w_st_wdata : '0;
  assign ram_wmask    = ram_wen ? w_st_wmask : '0;

  zero_store_align u_align (
    .i_size       (ls_req_size),
    .i_off        (ls_req_addr[2:0]),
    .i_wdata      (ls_req_wdata),
    .o_wdata      (w_st_wdata),
    .o_wmask      (w_st_wmask),
    .o_misaligned (w_ls_mis),
    .i_ld_size    (r_ls_pend.size),
    .i_ld_off     (r_ls_pend.off),
    .i_ld_rdata   (ram_rdata),
    .o_ld_data    (w_ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_vld  <= 1'b0;
      r_if_hi   <= 1'b0;
      r_ls_pend <= '0;
    end else begin
      r_if_vld       <= w_if_hit;
      r_if_hi        <= if_req_addr[2];
      r_ls_pend.vld  <= ls_req_valid;
      r_ls_pend.src  <= w_ls_mis ? PEND_SRC_ERR : (ls_req_we ? PEND_SRC_STORE : PEND_SRC_LS);
      r_ls_pend.off  <= ls_req_addr[2:0];
      r_ls_pend.size <= ls_req_size;
    end
  end

  assign if_rsp_valid = r_if_vld;
  assign if_rsp_inst  = !r_if_vld ? '0 : (r_if_hi ? ram_rdata[63:32] : ram_rdata[31:0]);
  assign ls_rsp_valid = r_ls_pend.vld;
  assign ls_rsp_err   = r_ls_pend.vld && (r_ls_pend.src == PEND_SRC_ERR);
  assign ls_rsp_rdata = (r_ls_pend.vld && (r_ls_pend.src == PEND_SRC_LS)) ? w_ld_data : '0;

`ifdef MEM_BRIDGE_PERF_EN
  logic [31:0] r_perf_if_stall;
  logic [31:0] r_perf_ls_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_if_stall <= '0;
      r_perf_ls_cnt   <= '0;
    end else begin
      if (if_req_valid && w_ld_hit && (r_perf_if_stall != 32'hFFFF_FFFF))
        r_perf_if_stall <= r_perf_if_stall + 32'd1;
      if (ls_req_valid && (r_perf_ls_cnt != 32'hFFFF_FFFF))
        r_perf_ls_cnt <= r_perf_ls_cnt + 32'd1;
    end
  end

  assign perf_if_stall = r_perf_if_stall;
  assign perf_ls_cnt   = r_perf_ls_cnt;
`endif

endmodule

// File: tb/tb_zero_mem_bridge.sv
// Bench for zero_mem_bridge: directed vector table, hand-written corner sequences and a
// randomized run scored against a byte-level reference of the RAM contents.
module tb_zero_mem_bridge;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_valid = 1'b0;
  logic [63:0] if_req_addr = '0;
  logic        ls_req_valid = 1'b0;
  logic        ls_req_we = 1'b0;
  logic [1:0]  ls_req_size = '0;
  logic [63:0] ls_req_addr = '0;
  logic [63:0] ls_req_wdata = '0;
  logic [63:0] ram_rdata = '0;
  logic        if_req_ready, if_rsp_valid, ls_req_ready, ls_rsp_valid, ls_rsp_err;
  logic        ram_ren, ram_wen;
  logic [31:0] if_rsp_inst;
  logic [63:0] ls_rsp_rdata, ram_ridx, ram_widx, ram_wdata, ram_wmask;
`ifdef MEM_BRIDGE_PERF_EN
  logic [31:0] perf_if_stall, perf_ls_cnt;
`endif

  always #5 clk = ~clk;

  zero_mem_bridge dut (
    .clk          (clk),
    .rst          (rst),
`ifdef MEM_BRIDGE_PERF_EN
    .perf_if_stall(perf_if_stall),
    .perf_ls_cnt  (perf_ls_cnt),
`endif
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_addr  (if_req_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_inst  (if_rsp_inst),
    .ls_req_valid (ls_req_valid),
    .ls_req_ready (ls_req_ready),
    .ls_req_we    (ls_req_we),
    .ls_req_size  (ls_req_size),
    .ls_req_addr  (ls_req_addr),
    .ls_req_wdata (ls_req_wdata),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rsp_rdata (ls_rsp_rdata),
    .ls_rsp_err   (ls_rsp_err),
    .ram_ren      (ram_ren),
    .ram_ridx     (ram_ridx),
    .ram_rdata    (ram_rdata),
    .ram_wen      (ram_wen),
    .ram_widx     (ram_widx),
    .ram_wdata    (ram_wdata),
    .ram_wmask    (ram_wmask)
  );

  // RAMHelper stand-in: registered read, masked write, read sees the pre-write word
  logic [63:0] ram_mem [16];
  always @(posedge clk) begin
    if (ram_ren) ram_rdata <= ram_mem[ram_ridx[3:0]];
    if (ram_wen)
      ram_mem[ram_widx[3:0]] = (ram_mem[ram_widx[3:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        if_v;
    logic [31:0] inst;
    logic        ls_v;
    logic        err;
    logic [63:0] rdata;
  } rsp_t;
  localparam int RSP_W = $bits(rsp_t);
  logic [RSP_W-1:0] exp_q[$];
  logic [63:0] ref_mem [16];

  task automatic chk_rsp(input string pfx, input rsp_t e);
    chk({pfx, "_if_rsp_valid"}, if_rsp_valid, e.if_v);
    if (e.if_v) chk({pfx, "_if_rsp_inst"}, if_rsp_inst, e.inst);
    chk({pfx, "_ls_rsp_valid"}, ls_rsp_valid, e.ls_v);
    if (e.ls_v) begin
      chk({pfx, "_ls_rsp_err"}, ls_rsp_err, e.err);
      chk({pfx, "_ls_rsp_rdata"}, ls_rsp_rdata, e.rdata);
    end
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_if_req_ready"}, if_req_ready, 0);
    chk({pfx, "_if_rsp_valid"}, if_rsp_valid, 0);
    chk({pfx, "_if_rsp_inst"},  if_rsp_inst, 0);
    chk({pfx, "_ls_req_ready"}, ls_req_ready, 1);
    chk({pfx, "_ls_rsp_valid"}, ls_rsp_valid, 0);
    chk({pfx, "_ls_rsp_rdata"}, ls_rsp_rdata, 0);
    chk({pfx, "_ls_rsp_err"},   ls_rsp_err, 0);
    chk({pfx, "_ram_ren"},      ram_ren, 0);
    chk({pfx, "_ram_ridx"},     ram_ridx, 0);
    chk({pfx, "_ram_wen"},      ram_wen, 0);
    chk({pfx, "_ram_widx"},     ram_widx, 0);
    chk({pfx, "_ram_wdata"},    ram_wdata, 0);
    chk({pfx, "_ram_wmask"},    ram_wmask, 0);
  endtask

  task automatic drive(input logic ifv, input logic [63:0] ifa, input logic lsv, input logic we,
                       input logic [1:0] sz, input logic [63:0] lsa, input logic [63:0] wd);
    if_req_valid = ifv;  if_req_addr  = ifa;
    ls_req_valid = lsv;  ls_req_we    = we;  ls_req_size = sz;
    ls_req_addr  = lsa;  ls_req_wdata = wd;
  endtask

  task automatic drive_idle();
    drive(1'b0, '0, 1'b0, 1'b0, 2'd0, '0, '0);
  endtask

  typedef struct {
    logic        if_v;  logic [63:0] if_addr;
    logic        ls_v;  logic we;  logic [1:0] size;  logic [63:0] ls_addr;  logic [63:0] wdata;
    logic        e_rdy; logic e_ren; logic [63:0] e_ridx;
    logic        e_wen; logic [63:0] e_widx; logic [63:0] e_wdata; logic [63:0] e_wmask;
    logic        e_ifv; logic [31:0] e_inst;
    logic        e_lsv; logic e_err; logic [63:0] e_rdata;
  } vec_t;
  vec_t vecs[10];

  task automatic apply_vec(input vec_t v, input int idx);
    rsp_t e;
    string pfx;
    pfx = $sformatf("vec%0d", idx);
    drive(v.if_v, v.if_addr, v.ls_v, v.we, v.size, v.ls_addr, v.wdata);
    #4;
    chk({pfx, "_if_req_ready"}, if_req_ready, v.e_rdy);
    chk({pfx, "_ram_ren"}, ram_ren, v.e_ren);
    if (v.e_ren) chk({pfx, "_ram_ridx"}, ram_ridx, v.e_ridx);
    chk({pfx, "_ram_wen"}, ram_wen, v.e_wen);
    if (v.e_wen) begin
      chk({pfx, "_ram_widx"}, ram_widx, v.e_widx);
      chk({pfx, "_ram_wdata"}, ram_wdata, v.e_wdata);
      chk({pfx, "_ram_wmask"}, ram_wmask, v.e_wmask);
    end
    @(posedge clk); #1;
    drive_idle();
    #4;
    e = '{if_v: v.e_ifv, inst: v.e_inst, ls_v: v.e_lsv, err: v.e_err, rdata: v.e_rdata};
    chk_rsp(pfx, e);
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] lane_extract(input logic [63:0] word, input int off, input int nb);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < nb; b++) r[8*b +: 8] = word[8*(off+b) +: 8];
    return r;
  endfunction

  task automatic rand_cycle();
    logic        ifv, lsv, we, mis, ld, st, e_rdy, if_acc, e_ren;
    logic [1:0]  sz;
    int          if_w, ls_w, off, nb;
    logic [63:0] ifa, lsa, wd, word, e_ridx, e_wmask;
    rsp_t        e, prev;
    ifv  = 1'($urandom_range(0, 1));
    if_w = $urandom_range(0, 15);
    ifa  = BASE + 64'(8 * if_w) + 64'($urandom_range(0, 7));
    lsv  = ($urandom_range(0, 3) != 0);
    we   = 1'($urandom_range(0, 1));
    sz   = 2'($urandom_range(0, 3));
    nb   = 1 << sz;
    ls_w = $urandom_range(0, 15);
    off  = $urandom_range(0, 7);
    if ($urandom_range(0, 2) != 0) off = (off / nb) * nb;
    lsa  = BASE + 64'(8 * ls_w) + 64'(off);
    wd   = {$urandom, $urandom};

    mis    = lsv && ((off % nb) != 0);
    ld     = lsv && !we && !mis;
    st     = lsv && we && !mis;
    e_rdy  = !ld;
    if_acc = ifv && e_rdy;
    e_ren  = ld || if_acc;
    e_ridx = ld ? (lsa - BASE) / 8 : (ifa - BASE) / 8;
    e_wmask = '0;
    for (int b = 0; b < nb; b++) e_wmask[8*(off+b) +: 8] = 8'hFF;

    drive(ifv, ifa, lsv, we, sz, lsa, wd);
    #4;
    chk("rand_if_req_ready", if_req_ready, e_rdy);
    chk("rand_ram_ren", ram_ren, e_ren);
    if (e_ren) chk("rand_ram_ridx", ram_ridx, e_ridx);
    chk("rand_ram_wen", ram_wen, st);
    if (st) begin
      chk("rand_ram_widx", ram_widx, (lsa - BASE) / 8);
      chk("rand_ram_wdata", ram_wdata, wd << (8 * off));
      chk("rand_ram_wmask", ram_wmask, e_wmask);
    end
    prev = exp_q.pop_front();
    chk_rsp("rand", prev);

    word     = ref_mem[if_w];
    e.if_v   = if_acc;
    e.inst   = ((ifa % 8) >= 4) ? word[63:32] : word[31:0];
    e.ls_v   = lsv;
    e.err    = mis;
    e.rdata  = ld ? lane_extract(ref_mem[ls_w], off, nb) : 64'h0;
    exp_q.push_back(e);
    if (st) begin
      word = ref_mem[ls_w];
      for (int b = 0; b < nb; b++) word[8*(off+b) +: 8] = wd[8*b +: 8];
      ref_mem[ls_w] = word;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rsp_t idle_rsp;
    vecs[0] = '{1'b1, 64'h8000_0004, 1'b0, 1'b0, 2'd0, 64'h0, 64'h0,
                1'b1, 1'b1, 64'h0, 1'b0, 64'h0, 64'h0, 64'h0,
                1'b1, 32'h1234_5678, 1'b0, 1'b0, 64'h0};
    vecs[1] = '{1'b0, 64'h0, 1'b1, 1'b0, 2'd1, 64'h8000_000A, 64'h0,
                1'b0, 1'b1, 64'h1, 1'b0, 64'h0, 64'h0, 64'h0,
                1'b0, 32'h0, 1'b1, 1'b0, 64'h4455};
    vecs[2] = '{1'b0, 64'h0, 1'b1, 1'b1, 2'd0, 64'h8000_0013, 64'hAB,
                1'b1, 1'b0, 64'h0, 1'b1, 64'h2, 64'hAB00_0000, 64'hFF00_0000,
                1'b0, 32'h0, 1'b1, 1'b0, 64'h0};
    vecs[3] = '{1'b1, 64'h8000_0000, 1'b1, 1'b0, 2'd2, 64'h8000_0002, 64'h0,
                1'b1, 1'b1, 64'h0, 1'b0, 64'h0, 64'h0, 64'h0,
                1'b1, 32'h9ABC_DEF0, 1'b1, 1'b1, 64'h0};
    vecs[4] = '{1'b1, 64'h8000_0008, 1'b1, 1'b0, 2'd3, 64'h8000_0008, 64'h0,
                1'b0, 1'b1, 64'h1, 1'b0, 64'h0, 64'h0, 64'h0,
                1'b0, 32'h0, 1'b1, 1'b0, 64'h0011_2233_4455_6677};
    vecs[5] = '{1'b1, 64'h8000_0008, 1'b1, 1'b1, 2'd2, 64'h8000_0014, 64'hDEAD_BEEF,
                1'b1, 1'b1, 64'h1, 1'b1, 64'h2, 64'hDEAD_BEEF_0000_0000, 64'hFFFF_FFFF_0000_0000,
                1'b1, 32'h4455_6677, 1'b1, 1'b0, 64'h0};
    vecs[6] = '{1'b0, 64'h0, 1'b1, 1'b1, 2'd1, 64'h8000_0011, 64'h1234,
                1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 64'h0,
                1'b0, 32'h0, 1'b1, 1'b1, 64'h0};
    vecs[7] = '{1'b0, 64'h0, 1'b1, 1'b0, 2'd3, 64'h7FFF_FFF8, 64'h0,
                1'b0, 1'b1, 64'h1FFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 64'h0, 64'h0,
                1'b0, 32'h0, 1'b1, 1'b0, 64'hFEDC_BA98_7654_3210};
    vecs[8] = '{1'b0, 64'h0, 1'b1, 1'b0, 2'd0, 64'h8000_000E, 64'h0,
                1'b0, 1'b1, 64'h1, 1'b0, 64'h0, 64'h0, 64'h0,
                1'b0, 32'h0, 1'b1, 1'b0, 64'h11};
    vecs[9] = '{1'b0, 64'h0, 1'b1, 1'b1, 2'd3, 64'h8000_0018, 64'h0102_0304_0506_0708,
                1'b1, 1'b0, 64'h0, 1'b1, 64'h3, 64'h0102_0304_0506_0708, 64'hFFFF_FFFF_FFFF_FFFF,
                1'b0, 32'h0, 1'b1, 1'b0, 64'h0};

    for (int i = 0; i < 16; i++) ram_mem[i] = '0;
    ram_mem[0]  = 64'h1234_5678_9ABC_DEF0;
    ram_mem[1]  = 64'h0011_2233_4455_6677;
    ram_mem[15] = 64'hFEDC_BA98_7654_3210;

    // clock/reset
    drive_idle();
    #12;
    chk_reset_outs("reset");
    #10 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) apply_vec(vecs[i], i);

    // fetch collides with load: fetch held off one cycle, then served
    drive(1'b1, 64'h8000_0004, 1'b1, 1'b0, 2'd3, 64'h8000_0008, 64'h0);
    #4;
    chk("coll_if_req_ready_n", if_req_ready, 0);
    chk("coll_ram_ridx_n", ram_ridx, 1);
    @(posedge clk); #1;
    drive(1'b1, 64'h8000_0004, 1'b0, 1'b0, 2'd0, 64'h0, 64'h0);
    #4;
    chk("coll_if_req_ready_n1", if_req_ready, 1);
    chk("coll_ram_ren_n1", ram_ren, 1);
    chk("coll_ram_ridx_n1", ram_ridx, 0);
    chk("coll_ls_rsp_valid_n1", ls_rsp_valid, 1);
    chk("coll_ls_rsp_rdata_n1", ls_rsp_rdata, 64'h0011_2233_4455_6677);
    chk("coll_if_rsp_valid_n1", if_rsp_valid, 0);
    @(posedge clk); #1;
    drive_idle();
    #4;
    chk("coll_if_rsp_valid_n2", if_rsp_valid, 1);
    chk("coll_if_rsp_inst_n2", if_rsp_inst, 32'h1234_5678);
    chk("coll_ls_rsp_valid_n2", ls_rsp_valid, 0);
    @(posedge clk); #1;

    // reset between accept and response: no response ever appears
    drive(1'b1, 64'h8000_0000, 1'b1, 1'b0, 2'd3, 64'h8000_0000, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 64'h8000_0000, 1'b1, 1'b1, 2'd3, 64'h8000_0000, 64'hFFFF);
    #3;
    chk_reset_outs("midrst");
    @(posedge clk); #1;
    chk("midrst_ls_rsp_valid_held", ls_rsp_valid, 0);
    drive_idle();
    #2 rst = 1'b1;
    @(posedge clk); #1;
    #4;
    chk("midrst_ls_rsp_valid_after", ls_rsp_valid, 0);
    chk("midrst_if_rsp_valid_after", if_rsp_valid, 0);
    @(posedge clk); #1;

    // randomized run against the reference memory
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = {$urandom, $urandom};
      ram_mem[i] = ref_mem[i];
    end
    idle_rsp = '0;
    exp_q.push_back(idle_rsp);
    for (int n = 0; n < 400; n++) rand_cycle();
    drive_idle();
    #4;
    idle_rsp = exp_q.pop_front();
    chk_rsp("rand_last", idle_rsp);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
